// File: rtl/pattern_stream_gen.sv
// Bit-serial pattern source for the d/valid link feeding the sequence detectors.
// Sends N copies of PATTERN MSB first, either overlapped by OVL_LEN bits or separated by GAP_LEN zeros.
module pattern_stream_gen #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
  parameter int                 OVL_LEN = 2,
  parameter int                 GAP_LEN = 2,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_i,
  input  logic             overlap_i,
  input  logic             ready_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(PAT_LEN - 1 - OVL_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [3:0]       GAP_LAST = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [3:0]       gap_cnt_r;
  logic [CNT_W-1:0] num_r;
  logic             ovl_r;

  logic             xfer_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             last_copy_s;

  // Handshake and end-of-command decode, all from registered state
  always_comb begin
    xfer_s      = valid_o & ready_i;
    cnt_next_s  = sent_cnt_o + CNT_ONE;
    last_copy_s = (cnt_next_s == num_r);
  end

  // Control FSM; d_o/valid_o are loaded with the next bit on each transfer so ready_i never reaches them combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= IDX_ZERO;
      gap_cnt_r  <= 4'd0;
      num_r      <= CNT_ZERO;
      ovl_r      <= 1'b0;
      d_o        <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sent_cnt_o <= CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            num_r      <= num_i;
            ovl_r      <= overlap_i;
            sent_cnt_o <= CNT_ZERO;
            idx_r      <= IDX_TOP;
            gap_cnt_r  <= 4'd0;
            if (num_i == CNT_ZERO) begin
              state_r <= DONE;
              done_o  <= 1'b1;
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              d_o     <= 1'b0;
            end else begin
              state_r <= SEND;
              valid_o <= 1'b1;
              busy_o  <= 1'b1;
              d_o     <= PATTERN[IDX_TOP];
            end
          end else begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            d_o     <= 1'b0;
          end
        end

        SEND: begin
          if (xfer_s) begin
            if (idx_r == IDX_ZERO) begin
              sent_cnt_o <= cnt_next_s;
              if (last_copy_s) begin
                state_r <= DONE;
                valid_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
                d_o     <= 1'b0;
              end else if (ovl_r) begin
                // Shared prefix is already on the wire, resume after it
                idx_r <= IDX_OVL;
                d_o   <= PATTERN[IDX_OVL];
              end else if (GAP_LEN > 0) begin
                state_r   <= GAP;
                gap_cnt_r <= 4'd0;
                d_o       <= 1'b0;
              end else begin
                idx_r <= IDX_TOP;
                d_o   <= PATTERN[IDX_TOP];
              end
            end else begin
              idx_r <= idx_r - IDX_ONE;
              d_o   <= PATTERN[idx_r - IDX_ONE];
            end
          end else begin
            idx_r <= idx_r;
          end
        end

        GAP: begin
          if (xfer_s) begin
            if (gap_cnt_r == GAP_LAST) begin
              state_r   <= SEND;
              gap_cnt_r <= 4'd0;
              idx_r     <= IDX_TOP;
              d_o       <= PATTERN[IDX_TOP];
            end else begin
              gap_cnt_r <= gap_cnt_r + 4'd1;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r;
          end
        end

        DONE: begin
          state_r <= IDLE;
          done_o  <= 1'b0;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          d_o     <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          d_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Scoreboard bench for pattern_stream_gen: expected bits are queued at command time and
// popped as the sink accepts them; also checks stalls, done timing, counts and detections.
module tb_pattern_stream_gen;

  localparam logic [4:0] PAT = 5'b10110;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic [7:0] num_i;
  logic       overlap_i;
  logic       ready;
  logic       d_o;
  logic       valid_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sent_cnt_o;

  typedef struct packed {
    logic       d;
    logic [7:0] cnt;
    logic       last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors;
  int   errors;
  int   xfer_cnt;
  int   det_cnt;
  int   xb;
  int   db;
  int   nbits;
  logic [4:0] sh;
  bit   expect_done;
  bit   done_chk;
  bit   prev_stall;
  logic prev_d;
  int   rdy_mode;
  bit   stalled;
  int   stall_left;

  pattern_stream_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .num_i      (num_i),
    .overlap_i  (overlap_i),
    .ready_i    (ready),
    .d_o        (d_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .sent_cnt_o (sent_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sink: samples mid-cycle, a transfer happens at the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall  = 1'b0;
      expect_done = 1'b0;
      nbits       = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", valid_o, 1);
        check("hold_d", d_o, prev_d);
      end
      if (done_chk) check("done", done_o, expect_done);
      expect_done = 1'b0;
      if (done_o) nbits = 0;
      prev_stall = valid_o && !ready;
      prev_d     = d_o;
      if (valid_o && ready) begin
        xfer_cnt++;
        if (q.size() == 0) begin
          check("extra_bit", 1, 0);
        end else begin
          mon_e = q.pop_front();
          check("d", d_o, mon_e.d);
          check("cnt", sent_cnt_o, mon_e.cnt);
          if (mon_e.last) expect_done = 1'b1;
        end
        sh = {sh[3:0], d_o};
        nbits++;
        if (nbits >= 5 && sh == PAT) det_cnt++;
      end
    end
  end

  // Sink readiness patterns: always ready, the scripted stall, or random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        if (!stalled && (xfer_cnt - xb) == 2) begin
          stalled    = 1'b1;
          stall_left = 3;
        end
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else if (stalled) begin
          ready = !ready;
        end else begin
          ready = 1'b1;
        end
      end
      2: ready = 1'($urandom_range(0, 1));
      default: begin
        ready      = 1'b1;
        stalled    = 1'b0;
        stall_left = 0;
      end
    endcase
  end

  task automatic start_cmd(input int n, input bit ovl);
    for (int c = 0; c < n; c++) begin
      int hi;
      hi = (c == 0 || !ovl) ? 4 : 2;
      for (int b = hi; b >= 0; b--)
        q.push_back('{d: PAT[b], cnt: 8'(c), last: (c == n - 1 && b == 0)});
      if (!ovl && c < n - 1)
        repeat (2) q.push_back('{d: 1'b0, cnt: 8'(c + 1), last: 1'b0});
    end
    xb        = xfer_cnt;
    db        = det_cnt;
    start_i   = 1'b1;
    num_i     = 8'(n);
    overlap_i = ovl;
    @(posedge clk); #1;
    start_i   = 1'b0;
    num_i     = 8'($urandom);
    overlap_i = 1'($urandom);
    check("lat_valid", valid_o, (n != 0));
    check("lat_busy", busy_o, (n != 0));
    if (n != 0) check("lat_d", d_o, PAT[4]);
  endtask

  task automatic finish_cmd(input int n, input int exp_cycles);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (busy_o && cyc < 2000);
    if (cyc >= 2000) check("timeout", 1, 0);
    if (exp_cycles > 0) check("cycles", cyc, exp_cycles);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("q_empty", q.size(), 0);
    check("sent_final", sent_cnt_o, n);
    check("detections", det_cnt - db, n);
    check("idle_valid", valid_o, 0);
    check("idle_busy", busy_o, 0);
  endtask

  task automatic wait_xfers(input int k);
    int cyc;
    cyc = 0;
    while ((xfer_cnt - xb) < k && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 500) check("wait_timeout", 1, 0);
  endtask

  initial begin
    vectors = 0; errors = 0; xfer_cnt = 0; det_cnt = 0; xb = 0; db = 0;
    nbits = 0; sh = 5'd0; expect_done = 1'b0; done_chk = 1'b1;
    prev_stall = 1'b0; prev_d = 1'b0; rdy_mode = 0; stalled = 1'b0; stall_left = 0;
    rst = 1'b1; start_i = 1'b0; num_i = 8'd0; overlap_i = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_d", d_o, 0);
    check("rst_cnt", sent_cnt_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Overlap, 3 copies, free-flowing sink
    start_cmd(3, 1'b1);
    finish_cmd(3, 11);

    // Gapped, 2 copies
    start_cmd(2, 1'b0);
    finish_cmd(2, 12);

    // Overlap, 4 copies with stall then alternating ready
    rdy_mode = 1;
    start_cmd(4, 1'b1);
    finish_cmd(4, -1);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Zero copies: immediate done, no data
    done_chk = 1'b0;
    start_cmd(0, 1'b1);
    check("zero_done", done_o, 1);
    check("zero_cnt", sent_cnt_o, 0);
    @(posedge clk); #1;
    check("zero_done_end", done_o, 0);
    check("zero_valid", valid_o, 0);
    done_chk = 1'b1;
    @(posedge clk); #1;

    // Gapped, 5 copies; a second start during bit 7 must be ignored
    start_cmd(5, 1'b0);
    wait_xfers(6);
    start_i = 1'b1;
    num_i   = 8'd1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignore_busy", busy_o, 1);
    finish_cmd(5, -1);
    check("ignore_bits", xfer_cnt - xb, 33);

    // Reset during bit 4 of the second copy, then a clean restart
    start_cmd(3, 1'b0);
    wait_xfers(10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_valid", valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_cnt", sent_cnt_o, 0);
    check("abort_done", done_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start_cmd(2, 1'b1);
    finish_cmd(2, 8);

    // Random backpressure in both modes
    rdy_mode = 2;
    start_cmd(6, 1'b1);
    finish_cmd(6, -1);
    start_cmd(3, 1'b0);
    finish_cmd(3, -1);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Largest command: counter reaches 2^CNT_W-1
    start_cmd(255, 1'b1);
    finish_cmd(255, 767);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
